imem_fetch_ctrl: RTL and testbench

//  Sequences a single-port, byte-wide instruction memory (synchronous read,
//  1-cycle latency) for the core. Serves fetch requests by reading 4 bytes and

---
 rtl/imem_fetch_if.sv | 29 ++
 rtl/imem_fetch_ctrl.sv | 95 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Bundle of fetch, loader and memory-port signals for the instruction memory sequencer.
// The controller uses the slave modport. The core/loader/memory side uses the master modport.
interface imem_fetch_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_valid;
    logic [31:0]           fetch_instr;
    logic                  fetch_err;
    logic                  load_we;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [7:0]            load_data;
    logic                  load_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_we, load_addr, load_data, mem_rdata,
        output fetch_valid, fetch_instr, fetch_err, load_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_we, load_addr, load_data, mem_rdata,
        input  fetch_valid, fetch_instr, fetch_err, load_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Shares a byte-wide synchronous-read memory between a program loader and 32-bit instruction fetches.
// State table (state | meaning):
//   S_IDLE | loader owns the port; accepts a fetch when no write is pending
//   S_RD   | issues byte reads base+cnt; captures the previous byte each cycle
//   S_LAST | captures byte 3 and commits the assembled instruction
//   S_RESP | one-cycle fetch_valid pulse, with fetch_err for a misaligned pc
module imem_fetch_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    imem_fetch_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_LAST, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  err_q, err_d;
    logic [23:0]           bytes_q, bytes_d;
    logic [31:0]           instr_q, instr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            base_q  <= '0;
            err_q   <= 1'b0;
            bytes_q <= 24'h0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            err_q   <= err_d;
            bytes_q <= bytes_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        base_d          = base_q;
        err_d           = err_q;
        bytes_d         = bytes_q;
        instr_d         = instr_q;
        bus.load_ready  = (state_q == S_IDLE);
        bus.mem_we      = bus.load_we & (state_q == S_IDLE);
        bus.mem_wdata   = bus.load_data;
        bus.mem_addr    = bus.load_addr;
        bus.fetch_valid = (state_q == S_RESP);
        bus.fetch_err   = (state_q == S_RESP) & err_q;
        bus.fetch_instr = instr_q;

        case (state_q)
            S_IDLE: begin
                // A pending loader write always takes the port; the fetch waits.
                if (!bus.load_we && bus.fetch_req) begin
                    base_d = bus.fetch_addr[ADDR_WIDTH-1:0];
                    cnt_d  = 2'd0;
                    if (bus.fetch_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                bus.mem_addr = base_q + ADDR_WIDTH'(cnt_q);
                cnt_d        = cnt_q + 2'd1;
                case (cnt_q)
                    2'd1:    bytes_d[7:0]   = bus.mem_rdata;
                    2'd2:    bytes_d[15:8]  = bus.mem_rdata;
                    2'd3:    bytes_d[23:16] = bus.mem_rdata;
                    default: ;
                endcase
                if (cnt_q == 2'd3) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                bus.mem_addr = base_q + ADDR_WIDTH'(3);
                instr_d      = {bus.mem_rdata, bytes_q};
                state_d      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and randomized checks of imem_fetch_ctrl against a byte-array memory and a shadow copy
// of what the loader has written; expected instructions come from the shadow copy.
module tb_imem_fetch_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_if #(.ADDR_WIDTH(AW)) bus ();
    imem_fetch_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  mem    [0:1023];
    logic [7:0]  shadow [0:1023];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instr;

    // Synchronous-read memory, one cycle of latency.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        b = int'(a & 32'h3FC);
        return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
    endfunction

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.fetch_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        #1;
        chk("wr_ready", {31'b0, bus.load_ready}, 32'd1);
        chk("wr_mem_we", {31'b0, bus.mem_we}, 32'd1);
        tick();
        bus.load_we = 1'b0;
        shadow[a]   = d;
    endtask

    task automatic do_fetch(input logic [31:0] a, input string tag);
        int lat;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        #1;
        chk({tag, "_idle"}, {31'b0, bus.load_ready}, 32'd1);
        tick();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = $urandom;
        wait_resp(lat);
        chk({tag, "_lat"}, lat, (a[1:0] != 2'b00) ? 32'd1 : 32'd6);
        chk({tag, "_err"}, {31'b0, bus.fetch_err}, {31'b0, (a[1:0] != 2'b00)});
        if (a[1:0] == 2'b00) exp_instr = model_word(a);
        chk({tag, "_instr"}, bus.fetch_instr, exp_instr);
        tick();
        chk({tag, "_pulse"}, {31'b0, bus.fetch_valid}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          n;
        int          seen;
        logic [31:0] ra;
        logic [7:0]  w;

        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        exp_instr      = 32'h0;
        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'h0;
        bus.load_we    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = 8'h00;
        tick();
        tick();
        chk("rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
        chk("rst_err", {31'b0, bus.fetch_err}, 32'd0);
        chk("rst_instr", bus.fetch_instr, 32'h0);
        chk("rst_ready", {31'b0, bus.load_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Basic aligned fetch.
        do_write(10'h000, 8'h13);
        do_write(10'h001, 8'h00);
        do_write(10'h002, 8'h00);
        do_write(10'h003, 8'h00);
        do_fetch(32'h0, "t1");
        chk("t1_const", bus.fetch_instr, 32'h00000013);

        // Top word, then the same word through an aliased address.
        do_write(10'h3FC, 8'hEF);
        do_write(10'h3FD, 8'hBE);
        do_write(10'h3FE, 8'hAD);
        do_write(10'h3FF, 8'hDE);
        do_fetch(32'h3FC, "t2a");
        chk("t2a_const", bus.fetch_instr, 32'hDEADBEEF);
        do_write(10'h000, 8'h55);
        do_fetch(32'h0, "t2b");
        do_fetch(32'h7FC, "t2c");
        chk("t2c_const", bus.fetch_instr, 32'hDEADBEEF);

        // Misaligned: immediate error response, no read of the target bytes.
        bus.load_addr  = '0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h6;
        tick();
        bus.fetch_req = 1'b0;
        #1;
        chk("t3_noread", {31'b0, (bus.mem_addr >= 10'd6 && bus.mem_addr <= 10'd9)}, 32'd0);
        chk("t3_we", {31'b0, bus.mem_we}, 32'd0);
        chk("t3_valid", {31'b0, bus.fetch_valid}, 32'd1);
        chk("t3_err", {31'b0, bus.fetch_err}, 32'd1);
        chk("t3_instr", bus.fetch_instr, 32'hDEADBEEF);
        tick();
        do_fetch(32'h6, "t3b");

        // Loader beats a simultaneous fetch; loader blocked during a fetch.
        bus.load_we    = 1'b1;
        bus.load_addr  = 10'h010;
        bus.load_data  = 8'h5A;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h10;
        #1;
        chk("t4_ready", {31'b0, bus.load_ready}, 32'd1);
        chk("t4_we", {31'b0, bus.mem_we}, 32'd1);
        tick();
        bus.load_we    = 1'b0;
        shadow[10'h010] = 8'h5A;
        #1;
        chk("t4_still_idle", {31'b0, bus.load_ready}, 32'd1);
        tick();
        bus.fetch_req = 1'b0;
        wait_resp(lat);
        chk("t4_lat", lat, 32'd6);
        chk("t4_instr", bus.fetch_instr, model_word(32'h10));
        tick();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h20;
        tick();
        bus.fetch_req = 1'b0;
        bus.load_we   = 1'b1;
        bus.load_addr = 10'h021;
        bus.load_data = 8'h77;
        #1;
        chk("t4_rd_ready", {31'b0, bus.load_ready}, 32'd0);
        chk("t4_rd_we", {31'b0, bus.mem_we}, 32'd0);
        wait_resp(lat);
        bus.load_we = 1'b0;
        chk("t4_rd_lat", lat, 32'd6);
        chk("t4_rd_instr", bus.fetch_instr, model_word(32'h20));
        chk("t4_nowrite", {24'b0, mem[10'h021]}, {24'b0, shadow[10'h021]});
        tick();

        // Back-to-back fetches with the request held high.
        for (int i = 4; i < 8; i++) do_write(AW'(i), 8'($urandom));
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        tick();
        bus.fetch_addr = 32'h4;
        wait_resp(lat);
        chk("t5_lat0", lat, 32'd6);
        chk("t5_instr0", bus.fetch_instr, model_word(32'h0));
        n = 0;
        tick();
        n++;
        while (!bus.fetch_valid && n < 20) begin
            tick();
            n++;
        end
        bus.fetch_req = 1'b0;
        chk("t5_gap", n, 32'd7);
        chk("t5_instr1", bus.fetch_instr, model_word(32'h4));
        tick();

        // Reset in the middle of a fetch.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h3FC;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_valid", {31'b0, bus.fetch_valid}, 32'd0);
        chk("t6_err", {31'b0, bus.fetch_err}, 32'd0);
        chk("t6_instr", bus.fetch_instr, 32'h0);
        chk("t6_ready", {31'b0, bus.load_ready}, 32'd1);
        tick();
        rst       = 1'b0;
        exp_instr = 32'h0;
        seen      = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.fetch_valid) seen++;
        end
        chk("t6_noresp", seen, 32'd0);
        do_fetch(32'h3FC, "t6b");

        // Randomized loads and fetches over the low 64 words.
        for (int it = 0; it < 40; it++) begin
            w  = 8'($urandom_range(0, 63));
            ra = $urandom;
            ra[9:0] = {w, 2'b00};
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 4; k++) do_write(ra[9:0] + AW'(k), 8'($urandom));
            end else begin
                if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom_range(1, 3));
                do_fetch(ra, "rnd");
            end
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
